// File: rtl/qsys_interval_timer_gen2.sv
// qsys_interval_timer_gen2: Avalon-MM interval timer, 16-bit register slave over a COUNT_W-bit down-counter.
// Optional snapshot register at addresses 4/5 enabled by defining QSYS_TIMER_SNAPSHOT_EN.
module qsys_interval_timer_gen2 #(
  parameter int COUNT_W        = 32,
  parameter int RESET_PERIOD   = 999999,
  parameter bit START_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic [2:0]  address,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);
  localparam logic [COUNT_W-1:0] RST_P = COUNT_W'(RESET_PERIOD);
  logic [COUNT_W-1:0] counter, period, period_n;
  logic               run, run_n, cont, to, ito;
  logic [31:0]        per_x, snap_x;
  logic [15:0]        rd_mux;
  logic               wr, st_wr, ctl_wr, per_wr, timeout;
  assign wr      = chipselect & ~write_n;
  assign st_wr   = wr && address == 3'd0;
  assign ctl_wr  = wr && address == 3'd1;
  assign per_wr  = wr && (address == 3'd2 || address == 3'd3);
  assign timeout = run && counter == '0;
  assign irq     = to & ito;
  assign per_x   = 32'(period);
  always_comb begin
    period_n = period;
    if (wr && address == 3'd2) period_n[15:0] = writedata;
    if (wr && address == 3'd3) period_n[COUNT_W-1:16] = writedata[COUNT_W-17:0];
  end
  // STOP beats START; a period write always leaves the timer stopped.
  always_comb begin
    run_n = per_wr                  ? 1'b0 :
            ctl_wr && writedata[3]  ? 1'b0 :
            ctl_wr && writedata[2]  ? 1'b1 :
            timeout && !cont        ? 1'b0 : run;
  end
`ifdef QSYS_TIMER_SNAPSHOT_EN
  logic [COUNT_W-1:0] snapshot;
  always_ff @(posedge clk) begin
    if (!reset_n) snapshot <= '0;
    else if (wr && address == 3'd4) snapshot <= counter;
  end
  assign snap_x = 32'(snapshot);
`else
  assign snap_x = '0;
`endif
  always_comb begin
    rd_mux = address == 3'd0 ? {14'b0, run, to}   :
             address == 3'd1 ? {14'b0, cont, ito} :
             address == 3'd2 ? per_x[15:0]        :
             address == 3'd3 ? per_x[31:16]       :
             address == 3'd4 ? snap_x[15:0]       :
             address == 3'd5 ? snap_x[31:16]      : 16'h0000;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      counter  <= RST_P;
      period   <= RST_P;
      run      <= START_ON_RESET;
      cont     <= START_ON_RESET;
      to       <= 1'b0;
      ito      <= 1'b0;
      readdata <= '0;
    end else begin
      period   <= period_n;
      run      <= run_n;
      readdata <= rd_mux;
      counter  <= per_wr  ? period_n :
                  timeout ? period   :
                  run     ? counter - COUNT_W'(1) : counter;
      to       <= timeout | (to & ~st_wr);
      if (ctl_wr) {cont, ito} <= writedata[1:0];
    end
  end
endmodule
